// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: the R-type opcode, the ALU funct encodings,
// instruction field positions, and the decoded-field bundle handed to execute.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPCODE_R = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL     = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam int OPC_LSB = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    typedef struct packed {
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rd;
    } dec_fields_t;

    function automatic dec_fields_t split_fields(input logic [XLEN-1:0] instr);
        dec_fields_t f;
        f.opcode = instr[OPC_LSB +: 7];
        f.funct3 = instr[F3_LSB  +: 3];
        f.funct7 = instr[F7_LSB  +: 7];
        f.rd     = instr[RD_LSB  +: REG_AW];
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction, write-back and execute-side handshake bundle for decode_stage.
// master = surrounding pipeline (drives instructions, write-back, ready_in); slave = decode_stage.
interface decode_stage_if #(parameter int DATA_W = 32);

    logic [31:0]       instr_in;
    logic              instr_valid_in;
    logic              instr_ready_out;
    logic              wb_en_in;
    logic [4:0]        wb_addr_in;
    logic [DATA_W-1:0] wb_data_in;
    logic [6:0]        opcode_out;
    logic [2:0]        funct3_out;
    logic [6:0]        funct7_out;
    logic [DATA_W-1:0] data1_out;
    logic [DATA_W-1:0] data2_out;
    logic [4:0]        rd_out;
    logic              valid_out;
    logic              ready_in;
    logic              illegal_out;

    modport master (
        output instr_in, instr_valid_in, wb_en_in, wb_addr_in, wb_data_in, ready_in,
        input  instr_ready_out, opcode_out, funct3_out, funct7_out,
               data1_out, data2_out, rd_out, valid_out, illegal_out
    );

    modport slave (
        input  instr_in, instr_valid_in, wb_en_in, wb_addr_in, wb_data_in, ready_in,
        output instr_ready_out, opcode_out, funct3_out, funct7_out,
               data1_out, data2_out, rd_out, valid_out, illegal_out
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-to-read bypass, x0 fixed at 0.
// Writes land at the clock edge; no backpressure (write port always accepts).
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o
);

    logic [DATA_W-1:0] regs_q [REG_CNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write is forwarded so a reader never sees the stale value.
    assign rdata1_o = (raddr1_i == '0)                    ? '0      :
                      (we_i && (waddr_i == raddr1_i))     ? wdata_i :
                                                            regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                    ? '0      :
                      (we_i && (waddr_i == raddr2_i))     ? wdata_i :
                                                            regs_q[raddr2_i];

endmodule

// File: rtl/decode_stage.sv
// R-type decode: field split, operand read with write-back bypass, busy scoreboard for RAW stalls.
// 1-cycle latency into a single output register; outputs held while ready_in is low.
module decode_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  io
);
    import rv_pkg::*;

    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    dec_fields_t       fld_in;
    dec_fields_t       fld_q;
    dec_fields_t       fld_d;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data1_d;
    logic [DATA_W-1:0] data2_q;
    logic [DATA_W-1:0] data2_d;
    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_d;
    logic              valid_q;
    logic              valid_d;
    logic              illegal_q;
    logic              illegal_d;
    logic              rs1_wb_hit;
    logic              rs2_wb_hit;
    logic              hazard;
    logic              instr_ready;
    logic              accept;
    logic              is_rtype;

    assign rs1    = io.instr_in[RS1_LSB +: REG_AW];
    assign rs2    = io.instr_in[RS2_LSB +: REG_AW];
    assign fld_in = split_fields(io.instr_in);

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .AW      (REG_AW)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (io.wb_en_in),
        .waddr_i  (io.wb_addr_in),
        .wdata_i  (io.wb_data_in),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // A write-back landing this cycle resolves the hazard; the bypass supplies the value.
    assign rs1_wb_hit  = io.wb_en_in && (io.wb_addr_in == rs1);
    assign rs2_wb_hit  = io.wb_en_in && (io.wb_addr_in == rs2);
    assign hazard      = (busy_q[rs1] && !rs1_wb_hit) || (busy_q[rs2] && !rs2_wb_hit);
    assign instr_ready = (!valid_q || io.ready_in) && !hazard;
    assign accept      = io.instr_valid_in && instr_ready;
    assign is_rtype    = (fld_in.opcode == OPCODE_R);

    always_comb begin
        busy_d    = busy_q;
        valid_d   = valid_q;
        fld_d     = fld_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        illegal_d = accept && !is_rtype;

        if (io.wb_en_in) begin
            busy_d[io.wb_addr_in] = 1'b0;
        end
        // Set after clear: the newly accepted producer is younger than the retiring one.
        if (accept && is_rtype && (fld_in.rd != '0)) begin
            busy_d[fld_in.rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        if (accept) begin
            valid_d = is_rtype;
            if (is_rtype) begin
                fld_d   = fld_in;
                data1_d = rdata1;
                data2_d = rdata2;
            end
        end else if (io.ready_in) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            fld_q     <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            fld_q     <= fld_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
        end
    end

    assign io.instr_ready_out = instr_ready;
    assign io.opcode_out      = fld_q.opcode;
    assign io.funct3_out      = fld_q.funct3;
    assign io.funct7_out      = fld_q.funct7;
    assign io.rd_out          = fld_q.rd;
    assign io.data1_out       = data1_q;
    assign io.data2_out       = data2_q;
    assign io.valid_out       = valid_q;
    assign io.illegal_out     = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, reset-mid-operation sequence, random run vs reference model.
module tb_decode_stage;
    import rv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32)) bus ();

    decode_stage #(.DATA_W(32), .REG_CNT(32)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input logic vld, input logic [31:0] instr, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd, input logic rin);
        bus.instr_valid_in = vld;
        bus.instr_in       = instr;
        bus.wb_en_in       = wen;
        bus.wb_addr_in     = wa;
        bus.wb_data_in     = wd;
        bus.ready_in       = rin;
    endtask

    typedef struct {
        logic        vld;
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rin;
        logic        x_rdy;
        logic        x_vld;
        logic        x_ill;
        logic        chk_f;
        logic [6:0]  x_op;
        logic [2:0]  x_f3;
        logic [6:0]  x_f7;
        logic [31:0] x_d1;
        logic [31:0] x_d2;
        logic [4:0]  x_rd;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic [31:0] instr, input logic wen,
                                input logic [4:0] wa, input logic [31:0] wd, input logic rin,
                                input logic xr, input logic xv, input logic xi, input logic cf,
                                input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd);
        vec_t v;
        v.vld = vld; v.instr = instr; v.wen = wen; v.wa = wa; v.wd = wd; v.rin = rin;
        v.x_rdy = xr; v.x_vld = xv; v.x_ill = xi; v.chk_f = cf;
        v.x_op = op; v.x_f3 = f3; v.x_f7 = f7; v.x_d1 = d1; v.x_d2 = d2; v.x_rd = rd;
        return v;
    endfunction

    vec_t tbl [14];

    // Reference model state for the random phase.
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_vld, m_ill;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    logic [31:0] m_d1, m_d2;

    function automatic logic [31:0] m_read(input logic [4:0] s, input logic wen,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (s == 5'd0) return 32'd0;
        if (wen && wa == s) return wd;
        return m_regs[s];
    endfunction

    initial begin
        // add x7,x5,x6 / sub x8,x7,x5 / xor x10,x5,x6 / or x0,x0,x0 / and x11,x0,x0 / addi x12,x5,1 / add x13,x12,x0
        tbl[0]  = mk(1'b0, 32'h0,        1'b1, 5'd5, 32'h10,        1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[1]  = mk(1'b0, 32'h0,        1'b1, 5'd6, 32'h3,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[2]  = mk(1'b1, 32'h006283B3, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 32'h10, 32'h3,  5'd7);
        tbl[3]  = mk(1'b1, 32'h40538433, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[4]  = mk(1'b1, 32'h40538433, 1'b1, 5'd7, 32'h13,        1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h20, 32'h13, 32'h10, 5'd8);
        tbl[5]  = mk(1'b1, 32'h0062C533, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h20, 32'h13, 32'h10, 5'd8);
        tbl[6]  = mk(1'b1, 32'h0062C533, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h20, 32'h13, 32'h10, 5'd8);
        tbl[7]  = mk(1'b1, 32'h0062C533, 1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h20, 32'h13, 32'h10, 5'd8);
        tbl[8]  = mk(1'b1, 32'h0062C533, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd4, 7'h00, 32'h10, 32'h3,  5'd10);
        tbl[9]  = mk(1'b0, 32'h0,        1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[10] = mk(1'b1, 32'h00006033, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd6, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[11] = mk(1'b1, 32'h000075B3, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd7, 7'h00, 32'h0,  32'h0,  5'd11);
        tbl[12] = mk(1'b1, 32'h00128613, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'h00, 3'd0, 7'h00, 32'h0,  32'h0,  5'd0);
        tbl[13] = mk(1'b1, 32'h000606B3, 1'b0, 5'd0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'h33, 3'd0, 7'h00, 32'h0,  32'h0,  5'd13);

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        #13;
        check("rst_valid",   32'(bus.valid_out), 32'd0);
        check("rst_illegal", 32'(bus.illegal_out), 32'd0);
        check("rst_opcode",  32'(bus.opcode_out), 32'd0);
        check("rst_data1",   bus.data1_out, 32'd0);
        check("rst_rd",      32'(bus.rd_out), 32'd0);
        check("rst_ready",   32'(bus.instr_ready_out), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].vld, tbl[i].instr, tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].rin);
            #1;
            check($sformatf("v%0d_ready", i), 32'(bus.instr_ready_out), 32'(tbl[i].x_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i),   32'(bus.valid_out),   32'(tbl[i].x_vld));
            check($sformatf("v%0d_illegal", i), 32'(bus.illegal_out), 32'(tbl[i].x_ill));
            if (tbl[i].chk_f) begin
                check($sformatf("v%0d_opcode", i), 32'(bus.opcode_out), 32'(tbl[i].x_op));
                check($sformatf("v%0d_funct3", i), 32'(bus.funct3_out), 32'(tbl[i].x_f3));
                check($sformatf("v%0d_funct7", i), 32'(bus.funct7_out), 32'(tbl[i].x_f7));
                check($sformatf("v%0d_data1", i),  bus.data1_out,       tbl[i].x_d1);
                check($sformatf("v%0d_data2", i),  bus.data2_out,       tbl[i].x_d2);
                check($sformatf("v%0d_rd", i),     32'(bus.rd_out),     32'(tbl[i].x_rd));
            end
        end

        // Reset while add x7 is in flight and x7 is busy.
        @(negedge clk);
        drive(1'b1, 32'h006283B3, 1'b0, 5'd0, 32'h0, 1'b1);
        @(posedge clk);
        #1;
        check("mid_pre_valid", 32'(bus.valid_out), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_valid",  32'(bus.valid_out), 32'd0);
        check("mid_opcode", 32'(bus.opcode_out), 32'd0);
        check("mid_data1",  bus.data1_out, 32'd0);
        check("mid_data2",  bus.data2_out, 32'd0);
        check("mid_rd",     32'(bus.rd_out), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h40538433, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        check("post_rst_ready", 32'(bus.instr_ready_out), 32'd1);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus.valid_out), 32'd1);
        check("post_rst_data1", bus.data1_out, 32'd0);
        check("post_rst_data2", bus.data2_out, 32'd0);
        check("post_rst_rd",    32'(bus.rd_out), 32'd8);

        // Random phase from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
        end
        m_vld = 1'b0; m_ill = 1'b0;
        m_op = 7'd0; m_f7 = 7'd0; m_f3 = 3'd0; m_rd = 5'd0; m_d1 = 32'd0; m_d2 = 32'd0;

        for (int c = 0; c < 600; c++) begin
            logic [4:0]  s1, s2, d, wa;
            logic [2:0]  f3;
            logic [6:0]  f7, op;
            logic [31:0] ins, wd;
            logic        vld, rin, wen, haz, x_rdy, acc, isr;
            @(negedge clk);
            s1  = 5'($urandom_range(0, 7));
            s2  = 5'($urandom_range(0, 7));
            d   = 5'($urandom_range(0, 7));
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 1) ? F7_SUB : F7_BASE;
            op  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : OPCODE_R;
            ins = {f7, s2, s1, f3, d, op};
            vld = ($urandom_range(0, 4) != 0);
            rin = ($urandom_range(0, 3) != 0);
            wen = ($urandom_range(0, 2) != 0);
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            drive(vld, ins, wen, wa, wd, rin);
            #1;
            haz = 1'b0;
            if (s1 != 0 && m_busy[s1] && !(wen && wa == s1)) haz = 1'b1;
            if (s2 != 0 && m_busy[s2] && !(wen && wa == s2)) haz = 1'b1;
            x_rdy = (!m_vld || rin) && !haz;
            check("rnd_ready", 32'(bus.instr_ready_out), 32'(x_rdy));
            acc = vld && x_rdy;
            isr = (op == 7'b0110011);
            if (acc && isr) begin
                m_vld = 1'b1;
                m_op = op; m_f3 = f3; m_f7 = f7; m_rd = d;
                m_d1 = m_read(s1, wen, wa, wd);
                m_d2 = m_read(s2, wen, wa, wd);
            end else if (acc || rin) begin
                m_vld = 1'b0;
            end
            m_ill = acc && !isr;
            if (wen) begin
                if (wa != 0) m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (acc && isr && d != 0) m_busy[d] = 1'b1;
            @(posedge clk);
            #1;
            check("rnd_valid",   32'(bus.valid_out),   32'(m_vld));
            check("rnd_illegal", 32'(bus.illegal_out), 32'(m_ill));
            if (m_vld) begin
                check("rnd_opcode", 32'(bus.opcode_out), 32'(m_op));
                check("rnd_funct3", 32'(bus.funct3_out), 32'(m_f3));
                check("rnd_funct7", 32'(bus.funct7_out), 32'(m_f7));
                check("rnd_rd",     32'(bus.rd_out),     32'(m_rd));
                check("rnd_data1",  bus.data1_out,       m_d1);
                check("rnd_data2",  bus.data2_out,       m_d2);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
